canvas_fb_arbiter: RTL and testbench
====================================

Name: canvas_fb_arbiter

Overview:
Owns the single framebuffer write port of the canvas project. Shares it between two requesters and one sequencer:
- the button/brush painter (local cursor writes);
- the I2C slave (host pixel writes);
- a built-in full-canvas clear sweep.
It sits between the painter and the I2C slave on one side and the framebuffer RAM on the other. It enforces one write at a time, round-robin fairness, and back-pressure from the RAM.

Parameters:
X_BITS, 4, cursor x coordinate width (canvas width = 2**X_BITS).
Y_BITS, 4, cursor y coordinate width (canvas height = 2**Y_BITS).
CLEAR_COLOR, 3'b000, {R,G,B} value written by the clear sweep.

Ports:
clk  in  1  single design clock
rst_n  in  1  synchronous, active-low reset
paint_req  in  1  painter write request, held high until paint_ack
paint_x  in  X_BITS  painter pixel x
paint_y  in  Y_BITS  painter pixel y
paint_rgb  in  3  painter colour {R,G,B}
paint_ack  out  1  one-cycle pulse: painter write accepted by RAM
i2c_req  in  1  I2C write request, held high until i2c_ack
i2c_x  in  X_BITS  I2C pixel x
i2c_y  in  Y_BITS  I2C pixel y
i2c_rgb  in  3  I2C colour
i2c_ack  out  1  one-cycle pulse: I2C write accepted by RAM
clr_req  in  1  one-cycle pulse: request a full-canvas clear
clr_busy  out  1  high while a clear is pending or sweeping
clr_done  out  1  one-cycle pulse after the last clear write is accepted
fb_we  out  1  write strobe to framebuffer
fb_addr  out  X_BITS+Y_BITS  write address = {y, x}
fb_wdata  out  3  write data {R,G,B}
fb_ready  in  1  RAM accepts the write in any cycle where fb_we && fb_ready
stat_paint_cnt  out  8  painter grant count (ARB_STATS_EN)
stat_i2c_cnt  out  8  I2C grant count (ARB_STATS_EN)

Behaviour:
- Clocking and reset: all state updates on posedge clk. rst_n low at a clock edge drives every output to 0, sets state to IDLE, sets last_grant=I2C, clears clr_pending and clears the sweep counter.
- Reset mid-write or mid-clear abandons the operation; no ack or clr_done is issued.
- The fb_* outputs are registered.
- States: IDLE, WRITE, CLEAR.
- IDLE:
  - If clr_pending is set, go to CLEAR with the sweep counter at 0.
  - Otherwise, if exactly one req is high, grant it.
  - If both reqs are high, grant the requester that is not last_grant.
  - On grant: latch addr/data, set fb_we=1 next cycle, go to WRITE, update last_grant.
  - Result: latency from req high in IDLE to fb_we high is 1 cycle.
- WRITE:
  - Hold fb_we, fb_addr and fb_wdata stable until fb_ready is seen high.
  - In the accepting cycle, pulse the matching ack for exactly one cycle (registered; it is high in the cycle after acceptance). Drop fb_we in that same cycle. Return to IDLE.
  - Minimum 2 cycles per grant, so back-to-back requesters alternate.
- Requesters must hold req/x/y/rgb stable until ack. The arbiter samples them only at grant time.
- clr_req:
  - Sets clr_pending in any state.
  - A clr_req while clr_pending or CLEAR is already active is ignored (no restart).
  - A clear never pre-empts an in-flight WRITE. It starts at the next IDLE and beats any pending reqs.
  - clr_busy = clr_pending || state==CLEAR.
- CLEAR:
  - fb_we=1, fb_wdata=CLEAR_COLOR, fb_addr=counter.
  - The counter increments on each cycle with fb_we && fb_ready.
  - On acceptance at address 2**(X_BITS+Y_BITS)-1: pulse clr_done, clear clr_pending, return to IDLE.
  - The counter wraps to 0 without overflow side effects.
  - Painter and I2C requests stall (no ack) for the whole sweep.
- fb_ready low indefinitely stalls any state; no timeout.

Optional Feature:
ARB_STATS_EN.
- Defined: stat_paint_cnt and stat_i2c_cnt each increment on their requester's ack. They saturate at 8'hFF and reset to 0 only on rst_n.
- Undefined: both outputs are tied to 8'h00 and no counter flops are built.

Decomposition:
- Package canvas_pkg holds:
  - X_BITS/Y_BITS defaults;
  - the rgb_t 3-bit colour typedef;
  - the arbiter state enum {IDLE, WRITE, CLEAR};
  - the requester-id enum {GNT_PAINT, GNT_I2C}.
- Sub-module canvas_rr_arb2: a 2-way round-robin pick with a last_grant register, instantiated once.

Test Plan:
- Single painter write: paint_req=1 at (x=3, y=5, rgb=3'b101) with fb_ready=1 -> fb_we high 1 cycle later, fb_addr=8'h53, fb_wdata=3'b101, paint_ack pulses once, i2c_ack stays 0.
- Contention: paint_req and i2c_req both held from reset with fb_ready=1 -> grants alternate paint, i2c, paint, i2c.
- Back-pressure: fb_ready=0 for 5 cycles during a WRITE -> fb_we, fb_addr and fb_wdata are stable all 5 cycles; ack comes only after fb_ready=1.
- Clear during a write: clr_req while an I2C WRITE is stalled -> the I2C write completes first. Then 256 writes of CLEAR_COLOR to addresses 0..255 in order, then a clr_done pulse. A paint_req held throughout is acked only after clr_done.
- Reset mid-clear: rst_n=0 at sweep address 40 -> all outputs 0, no clr_done. After release with no requests, fb_we stays 0.
- Stats (ARB_STATS_EN): 300 painter acks -> stat_paint_cnt=8'hFF and stat_i2c_cnt=0. Without the macro, both stay 0.

Source files
------------

// File: rtl/canvas_pkg.sv
// ============================================================================
// Module   : canvas_pkg
// Brief    : Shared types for the canvas framebuffer write path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package canvas_pkg;

    localparam int X_BITS_DEF = 4;
    localparam int Y_BITS_DEF = 4;

    typedef logic [2:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_PAINT = 1'b0,
        GNT_I2C   = 1'b1
    } gnt_id_t;

endpackage

`default_nettype wire

// File: rtl/canvas_rr_arb2.sv
// ============================================================================
// Module   : canvas_rr_arb2
// Brief    : Two-way round-robin pick; contention goes to the side not last served.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module canvas_rr_arb2
    import canvas_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_req_paint,
    input  logic    i_req_i2c,
    input  logic    i_take,
    output logic    o_gnt_valid,
    output gnt_id_t o_gnt_id
);

    gnt_id_t r_last_grant;

    always_comb begin
        o_gnt_valid = i_req_paint | i_req_i2c;
        o_gnt_id    = GNT_PAINT;
        if (i_req_paint && i_req_i2c) begin
            o_gnt_id = (r_last_grant == GNT_PAINT) ? GNT_I2C : GNT_PAINT;
        end else if (i_req_i2c) begin
            o_gnt_id = GNT_I2C;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= GNT_I2C;
        end else if (i_take && o_gnt_valid) begin
            r_last_grant <= o_gnt_id;
        end
    end

endmodule

`default_nettype wire

// File: rtl/canvas_fb_arbiter.sv
// ============================================================================
// Module   : canvas_fb_arbiter
// Brief    : Framebuffer write-port owner: painter, I2C host and clear sweep.
//            Define ARB_STATS_EN to build the saturating grant counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module canvas_fb_arbiter
    import canvas_pkg::*;
#(
    parameter int   X_BITS      = X_BITS_DEF,
    parameter int   Y_BITS      = Y_BITS_DEF,
    parameter rgb_t CLEAR_COLOR = 3'b000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     paint_req,
    input  logic [X_BITS-1:0]        paint_x,
    input  logic [Y_BITS-1:0]        paint_y,
    input  logic [2:0]               paint_rgb,
    output logic                     paint_ack,
    input  logic                     i2c_req,
    input  logic [X_BITS-1:0]        i2c_x,
    input  logic [Y_BITS-1:0]        i2c_y,
    input  logic [2:0]               i2c_rgb,
    output logic                     i2c_ack,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     fb_we,
    output logic [X_BITS+Y_BITS-1:0] fb_addr,
    output logic [2:0]               fb_wdata,
    input  logic                     fb_ready,
    output logic [7:0]               stat_paint_cnt,
    output logic [7:0]               stat_i2c_cnt
);

    localparam int                  C_A_BITS    = X_BITS + Y_BITS;
    localparam logic [C_A_BITS-1:0] C_LAST_ADDR = '1;
    localparam logic [C_A_BITS-1:0] C_ONE       = {{(C_A_BITS-1){1'b0}}, 1'b1};

    arb_state_t          r_state, w_state_nxt;
    gnt_id_t             r_owner, w_owner_nxt;
    logic                r_clr_pending, w_clr_pending_nxt;
    logic [C_A_BITS-1:0] r_sweep_cnt, w_sweep_nxt;
    logic                r_fb_we, w_fb_we_nxt;
    logic [C_A_BITS-1:0] r_fb_addr, w_fb_addr_nxt;
    rgb_t                r_fb_wdata, w_fb_wdata_nxt;
    logic                r_paint_ack, w_paint_ack_nxt;
    logic                r_i2c_ack, w_i2c_ack_nxt;
    logic                r_clr_done, w_clr_done_nxt;

    logic    w_accept, w_clr_start, w_take, w_gnt_valid;
    logic    w_req_paint, w_req_i2c;
    gnt_id_t w_gnt_id;

    assign w_accept    = r_fb_we && fb_ready;
    assign w_clr_start = clr_req && !r_clr_pending && (r_state != CLEAR);
    assign w_take      = (r_state == IDLE) && !r_clr_pending;

    // A requester still sees its req high during its ack cycle; mask it so it
    // is not served twice for one request.
    assign w_req_paint = paint_req && !r_paint_ack;
    assign w_req_i2c   = i2c_req && !r_i2c_ack;

    canvas_rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_paint (w_req_paint),
        .i_req_i2c   (w_req_i2c),
        .i_take      (w_take),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (r_clr_pending)    w_state_nxt = CLEAR;
                else if (w_gnt_valid) w_state_nxt = WRITE;
            end
            WRITE: if (w_accept) w_state_nxt = IDLE;
            CLEAR: if (w_accept && (r_sweep_cnt == C_LAST_ADDR)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_fb_we_nxt       = r_fb_we;
        w_fb_addr_nxt     = r_fb_addr;
        w_fb_wdata_nxt    = r_fb_wdata;
        w_paint_ack_nxt   = 1'b0;
        w_i2c_ack_nxt     = 1'b0;
        w_clr_done_nxt    = 1'b0;
        w_sweep_nxt       = r_sweep_cnt;
        w_owner_nxt       = r_owner;
        w_clr_pending_nxt = r_clr_pending || w_clr_start;
        case (r_state)
            IDLE: begin
                if (r_clr_pending) begin
                    w_fb_we_nxt    = 1'b1;
                    w_fb_addr_nxt  = '0;
                    w_fb_wdata_nxt = CLEAR_COLOR;
                    w_sweep_nxt    = '0;
                end else if (w_gnt_valid) begin
                    w_fb_we_nxt = 1'b1;
                    w_owner_nxt = w_gnt_id;
                    if (w_gnt_id == GNT_PAINT) begin
                        w_fb_addr_nxt  = {paint_y, paint_x};
                        w_fb_wdata_nxt = paint_rgb;
                    end else begin
                        w_fb_addr_nxt  = {i2c_y, i2c_x};
                        w_fb_wdata_nxt = i2c_rgb;
                    end
                end
            end
            WRITE: begin
                if (w_accept) begin
                    w_fb_we_nxt     = 1'b0;
                    w_paint_ack_nxt = (r_owner == GNT_PAINT);
                    w_i2c_ack_nxt   = (r_owner == GNT_I2C);
                end
            end
            CLEAR: begin
                if (w_accept) begin
                    if (r_sweep_cnt == C_LAST_ADDR) begin
                        w_fb_we_nxt       = 1'b0;
                        w_clr_done_nxt    = 1'b1;
                        w_clr_pending_nxt = 1'b0;
                        w_sweep_nxt       = '0;
                    end else begin
                        w_sweep_nxt   = r_sweep_cnt + C_ONE;
                        w_fb_addr_nxt = r_sweep_cnt + C_ONE;
                    end
                end
            end
            default: w_fb_we_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fb_we       <= 1'b0;
            r_fb_addr     <= '0;
            r_fb_wdata    <= '0;
            r_paint_ack   <= 1'b0;
            r_i2c_ack     <= 1'b0;
            r_clr_done    <= 1'b0;
            r_sweep_cnt   <= '0;
            r_owner       <= GNT_PAINT;
            r_clr_pending <= 1'b0;
        end else begin
            r_fb_we       <= w_fb_we_nxt;
            r_fb_addr     <= w_fb_addr_nxt;
            r_fb_wdata    <= w_fb_wdata_nxt;
            r_paint_ack   <= w_paint_ack_nxt;
            r_i2c_ack     <= w_i2c_ack_nxt;
            r_clr_done    <= w_clr_done_nxt;
            r_sweep_cnt   <= w_sweep_nxt;
            r_owner       <= w_owner_nxt;
            r_clr_pending <= w_clr_pending_nxt;
        end
    end

    assign fb_we     = r_fb_we;
    assign fb_addr   = r_fb_addr;
    assign fb_wdata  = r_fb_wdata;
    assign paint_ack = r_paint_ack;
    assign i2c_ack   = r_i2c_ack;
    assign clr_done  = r_clr_done;
    assign clr_busy  = r_clr_pending || (r_state == CLEAR);

`ifdef ARB_STATS_EN
    logic [7:0] r_stat_paint;
    logic [7:0] r_stat_i2c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_paint <= 8'h00;
            r_stat_i2c   <= 8'h00;
        end else begin
            if (w_paint_ack_nxt && (r_stat_paint != 8'hFF)) r_stat_paint <= r_stat_paint + 8'd1;
            if (w_i2c_ack_nxt && (r_stat_i2c != 8'hFF))     r_stat_i2c   <= r_stat_i2c + 8'd1;
        end
    end

    assign stat_paint_cnt = r_stat_paint;
    assign stat_i2c_cnt   = r_stat_i2c;
`else
    assign stat_paint_cnt = 8'h00;
    assign stat_i2c_cnt   = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_canvas_fb_arbiter.sv
// ============================================================================
// Module   : tb_canvas_fb_arbiter
// Brief    : Self-checking bench for canvas_fb_arbiter (honours ARB_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_canvas_fb_arbiter;

    localparam logic [2:0] CLR_RGB = 3'b010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       paint_req, i2c_req, clr_req, fb_ready;
    logic [3:0] paint_x, paint_y, i2c_x, i2c_y;
    logic [2:0] paint_rgb, i2c_rgb;
    logic       paint_ack, i2c_ack, clr_busy, clr_done, fb_we;
    logic [7:0] fb_addr;
    logic [2:0] fb_wdata;
    logic [7:0] stat_paint_cnt, stat_i2c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         sel;       // 0 = painter, 1 = I2C
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] rgb;
        int         stall;     // WRITE cycles with fb_ready low
        logic [7:0] exp_addr;
        logic [2:0] exp_data;
    } vec_t;

    vec_t vecs[5];
    vec_t v;

    bit   stable, alt_ok, order_ok, paint_early, done_seen, busy_at_done, re_sent, got, quiet;
    int   seq_n, exp_a, timeouts, owner, new_owner, exp_owner, last_owner;
    bit   prev_we, prev_acc, prev_p, prev_i;
    int   p_iss, p_ack, i_iss, i_ack;
    logic [10:0] exp_hold;
    logic [7:0]  exp_sp, exp_si;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    canvas_fb_arbiter #(
        .X_BITS      (4),
        .Y_BITS      (4),
        .CLEAR_COLOR (CLR_RGB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .paint_req      (paint_req),
        .paint_x        (paint_x),
        .paint_y        (paint_y),
        .paint_rgb      (paint_rgb),
        .paint_ack      (paint_ack),
        .i2c_req        (i2c_req),
        .i2c_x          (i2c_x),
        .i2c_y          (i2c_y),
        .i2c_rgb        (i2c_rgb),
        .i2c_ack        (i2c_ack),
        .clr_req        (clr_req),
        .clr_busy       (clr_busy),
        .clr_done       (clr_done),
        .fb_we          (fb_we),
        .fb_addr        (fb_addr),
        .fb_wdata       (fb_wdata),
        .fb_ready       (fb_ready),
        .stat_paint_cnt (stat_paint_cnt),
        .stat_i2c_cnt   (stat_i2c_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {fb_we, fb_addr, fb_wdata, paint_ack, i2c_ack, clr_busy, clr_done,
                stat_paint_cnt, stat_i2c_cnt};
    endfunction

    initial begin
        vecs[0] = '{sel:1'b0, x:4'd3,  y:4'd5,  rgb:3'b101, stall:0, exp_addr:8'h53, exp_data:3'b101};
        vecs[1] = '{sel:1'b1, x:4'd15, y:4'd0,  rgb:3'b111, stall:0, exp_addr:8'h0F, exp_data:3'b111};
        vecs[2] = '{sel:1'b0, x:4'd0,  y:4'd15, rgb:3'b010, stall:5, exp_addr:8'hF0, exp_data:3'b010};
        vecs[3] = '{sel:1'b1, x:4'd10, y:4'd10, rgb:3'b011, stall:2, exp_addr:8'hAA, exp_data:3'b011};
        vecs[4] = '{sel:1'b0, x:4'd15, y:4'd15, rgb:3'b001, stall:1, exp_addr:8'hFF, exp_data:3'b001};

        rst_n = 1'b0; paint_req = 1'b0; i2c_req = 1'b0; clr_req = 1'b0; fb_ready = 1'b0;
        paint_x = '0; paint_y = '0; paint_rgb = '0; i2c_x = '0; i2c_y = '0; i2c_rgb = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_we", fb_we, 1'b0);

        // Table: single writes, optionally back-pressured
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            fb_ready = (v.stall == 0);
            if (v.sel) begin
                i2c_req = 1'b1; i2c_x = v.x; i2c_y = v.y; i2c_rgb = v.rgb;
            end else begin
                paint_req = 1'b1; paint_x = v.x; paint_y = v.y; paint_rgb = v.rgb;
            end
            @(negedge clk);
            check($sformatf("v%0d_we", i), fb_we, 1'b1);
            check($sformatf("v%0d_addr", i), fb_addr, v.exp_addr);
            check($sformatf("v%0d_data", i), fb_wdata, v.exp_data);
            stable = 1'b1;
            repeat (v.stall) begin
                @(negedge clk);
                if (fb_we !== 1'b1 || fb_addr !== v.exp_addr || fb_wdata !== v.exp_data ||
                    paint_ack !== 1'b0 || i2c_ack !== 1'b0) stable = 1'b0;
            end
            if (v.stall > 0) check($sformatf("v%0d_stall_hold", i), stable, 1'b1);
            fb_ready = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d_ack", i), {paint_ack, i2c_ack}, v.sel ? 2'b01 : 2'b10);
            check($sformatf("v%0d_we_drop", i), fb_we, 1'b0);
            paint_req = 1'b0; i2c_req = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_ack_pulse", i), {paint_ack, i2c_ack, fb_we}, 3'b000);
        end

        // Contention from reset: paint first, then strict alternation
        rst_n = 1'b0;
        paint_req = 1'b1; paint_x = 4'd1; paint_y = 4'd1; paint_rgb = 3'd1;
        i2c_req = 1'b1;   i2c_x = 4'd2;   i2c_y = 4'd2;   i2c_rgb = 3'd2;
        fb_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seq_n = 0; alt_ok = 1'b1;
        for (int c = 0; c < 40 && seq_n < 6; c++) begin
            @(negedge clk);
            if (paint_ack && i2c_ack) alt_ok = 1'b0;
            if (paint_ack || i2c_ack) begin
                if (i2c_ack !== ((seq_n % 2) == 1)) alt_ok = 1'b0;
                seq_n++;
            end
        end
        paint_req = 1'b0; i2c_req = 1'b0;
        check("contend_count", seq_n, 6);
        check("contend_alternate", alt_ok, 1'b1);
        repeat (3) @(negedge clk);

        // Clear requested while an I2C write is stalled
        fb_ready = 1'b0;
        i2c_req = 1'b1; i2c_x = 4'd1; i2c_y = 4'd2; i2c_rgb = 3'b011;
        @(negedge clk);
        check("clr_i2c_grant", {fb_we, fb_addr}, {1'b1, 8'h21});
        clr_req = 1'b1;
        paint_req = 1'b1; paint_x = 4'd4; paint_y = 4'd4; paint_rgb = 3'b110;
        @(negedge clk);
        clr_req = 1'b0;
        check("clr_busy_set", clr_busy, 1'b1);
        check("clr_no_preempt", {fb_we, fb_addr, fb_wdata}, {1'b1, 8'h21, 3'b011});
        repeat (2) @(negedge clk);
        fb_ready = 1'b1;
        @(negedge clk);
        check("clr_i2c_ack_first", {paint_ack, i2c_ack}, 2'b01);
        i2c_req = 1'b0;
        exp_a = 0; order_ok = 1'b1; paint_early = 1'b0; done_seen = 1'b0;
        busy_at_done = 1'b1; re_sent = 1'b0;
        for (int c = 0; c < 1500 && !done_seen; c++) begin
            @(negedge clk);
            clr_req = 1'b0;
            if (paint_ack) paint_early = 1'b1;
            if (clr_done) begin
                done_seen = 1'b1;
                busy_at_done = clr_busy;
            end else if (fb_we) begin
                if (exp_a > 255 || fb_addr !== exp_a[7:0] || fb_wdata !== CLR_RGB) order_ok = 1'b0;
            end
            fb_ready = ($urandom_range(0, 3) != 0);
            if (fb_we && !clr_done && fb_ready) exp_a++;
            if (exp_a == 100 && !re_sent) begin
                clr_req = 1'b1;
                re_sent = 1'b1;
            end
        end
        fb_ready = 1'b1;
        check("clr_done_seen", done_seen, 1'b1);
        check("clr_write_count", exp_a, 256);
        check("clr_addr_order", order_ok, 1'b1);
        check("clr_paint_stalled", paint_early, 1'b0);
        check("clr_busy_at_done", busy_at_done, 1'b0);
        @(negedge clk);
        check("clr_done_pulse", clr_done, 1'b0);
        check("clr_paint_grant", {fb_we, fb_addr, fb_wdata}, {1'b1, 8'h44, 3'b110});
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (paint_ack) got = 1'b1;
        end
        paint_req = 1'b0;
        check("clr_paint_ack_after", got, 1'b1);
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (fb_we || clr_busy) quiet = 1'b0;
        end
        check("clr_no_restart", quiet, 1'b1);

        // Reset in the middle of a sweep
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (fb_we && fb_addr == 8'd40) got = 1'b1;
        end
        check("rst_reach_addr40", got, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_midclear_outputs", out_vec(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (fb_we || clr_done || clr_busy || paint_ack || i2c_ack) quiet = 1'b0;
        end
        check("rst_midclear_quiet", quiet, 1'b1);

        // Randomised traffic against a transaction-level scoreboard
        last_owner = 1; owner = 2;
        prev_we = 1'b0; prev_acc = 1'b0; prev_p = 1'b0; prev_i = 1'b0;
        p_iss = 0; p_ack = 0; i_iss = 0; i_ack = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("rnd_paint_ack", paint_ack, prev_acc && owner == 0);
            check("rnd_i2c_ack", i2c_ack, prev_acc && owner == 1);
            if (fb_we && !prev_we) begin
                if (paint_req && fb_addr == {paint_y, paint_x} && fb_wdata == paint_rgb)  new_owner = 0;
                else if (i2c_req && fb_addr == {i2c_y, i2c_x} && fb_wdata == i2c_rgb)    new_owner = 1;
                else new_owner = 2;
                if (prev_p && prev_i) exp_owner = 1 - last_owner;
                else if (prev_p)      exp_owner = 0;
                else if (prev_i)      exp_owner = 1;
                else                  exp_owner = 3;
                check("rnd_grant_owner", new_owner, exp_owner);
                owner = new_owner;
                if (new_owner < 2) last_owner = new_owner;
            end
            if (fb_we && owner < 2) begin
                exp_hold = (owner == 0) ? {paint_y, paint_x, paint_rgb} : {i2c_y, i2c_x, i2c_rgb};
                check("rnd_write_hold", {fb_addr, fb_wdata}, exp_hold);
            end
            if (paint_ack) begin paint_req = 1'b0; p_ack++; end
            if (i2c_ack)   begin i2c_req = 1'b0;   i_ack++; end
            if (!paint_req && !paint_ack && c < 2800 && $urandom_range(0, 2) == 0) begin
                paint_req = 1'b1;
                paint_x = {3'($urandom_range(0, 7)), 1'b0};
                paint_y = 4'($urandom_range(0, 15));
                paint_rgb = 3'($urandom_range(0, 7));
                p_iss++;
            end
            if (!i2c_req && !i2c_ack && c < 2800 && $urandom_range(0, 2) == 0) begin
                i2c_req = 1'b1;
                i2c_x = {3'($urandom_range(0, 7)), 1'b1};
                i2c_y = 4'($urandom_range(0, 15));
                i2c_rgb = 3'($urandom_range(0, 7));
                i_iss++;
            end
            fb_ready = ($urandom_range(0, 3) != 0);
            prev_acc = fb_we && fb_ready;
            prev_we = fb_we;
            prev_p = paint_req;
            prev_i = i2c_req;
        end
        check("rnd_paint_drained", p_ack, p_iss);
        check("rnd_i2c_drained", i_ack, i_iss);
`ifdef ARB_STATS_EN
        exp_sp = (p_ack > 255) ? 8'hFF : p_ack[7:0];
        exp_si = (i_ack > 255) ? 8'hFF : i_ack[7:0];
`else
        exp_sp = 8'h00;
        exp_si = 8'h00;
`endif
        check("rnd_stat_paint", stat_paint_cnt, exp_sp);
        check("rnd_stat_i2c", stat_i2c_cnt, exp_si);

        // 300 painter writes: saturating statistics
        rst_n = 1'b0; paint_req = 1'b0; i2c_req = 1'b0; fb_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        timeouts = 0;
        paint_x = 4'd7; paint_y = 4'd9; paint_rgb = 3'b100;
        for (int w = 0; w < 300; w++) begin
            paint_req = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (paint_ack) got = 1'b1;
            end
            paint_req = 1'b0;
            if (!got) timeouts++;
        end
        @(negedge clk);
        check("stats_ack_timeouts", timeouts, 0);
`ifdef ARB_STATS_EN
        exp_sp = 8'hFF;
`else
        exp_sp = 8'h00;
`endif
        check("stats_paint_cnt", stat_paint_cnt, exp_sp);
        check("stats_i2c_cnt", stat_i2c_cnt, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
